// File: rtl/decode_operand_stage.sv
// decode_operand_stage: decode/operand-fetch stage between the decode queue head
// and execute. Resolves operands per source channel by address comparison against
// the execute and writeback layers (falling back to the register file), interlocks
// on load-use hazards, and hands results to execute through a valid/ready interface
// backed by an output register plus one skid entry.
//
// Ports:
//   i_clk, i_rst                 clock, synchronous active-high reset
//   i_flush                      drop every held entry
//   i_in_valid / o_in_ready      queue-head handshake (o_in_ready is combinational)
//   i_in_payload                 opaque bundle, passed through unmodified
//   i_in_src_addr, i_in_src_use  per-channel source register address / read enable
//   i_gpr                        flattened architectural register file
//   i_exe_*                      instruction in execute: write enable, load flag, dest, result
//   i_wri_*                      per-writeback-layer write enable, dest, value
//   o_out_valid / i_out_ready    execute handshake
//   o_out_payload, o_out_src_addr, o_out_src_val  captured entry at the output
//   o_interlock_cnt              saturating count of load-use interlock cycles
module decode_operand_stage #(
  parameter int unsigned SRC_N      = 3,
  parameter int unsigned EW_LAYER   = 1,
  parameter int unsigned REG_W      = 64,
  parameter int unsigned REG_ADDR_W = 4,
  parameter int unsigned REG_N      = 16,
  parameter int unsigned PAYLOAD_W  = 128
) (
  input  logic                              i_clk,
  input  logic                              i_rst,
  input  logic                              i_flush,
  input  logic                              i_in_valid,
  output logic                              o_in_ready,
  input  logic [PAYLOAD_W-1:0]              i_in_payload,
  input  logic [SRC_N*REG_ADDR_W-1:0]       i_in_src_addr,
  input  logic [SRC_N-1:0]                  i_in_src_use,
  input  logic [REG_N*REG_W-1:0]            i_gpr,
  input  logic                              i_exe_wen,
  input  logic                              i_exe_is_load,
  input  logic [REG_ADDR_W-1:0]             i_exe_addr,
  input  logic [REG_W-1:0]                  i_exe_val,
  input  logic [EW_LAYER:0]                 i_wri_wen,
  input  logic [(EW_LAYER+1)*REG_ADDR_W-1:0] i_wri_addr,
  input  logic [(EW_LAYER+1)*REG_W-1:0]     i_wri_val,
  output logic                              o_out_valid,
  input  logic                              i_out_ready,
  output logic [PAYLOAD_W-1:0]              o_out_payload,
  output logic [SRC_N*REG_ADDR_W-1:0]       o_out_src_addr,
  output logic [SRC_N*REG_W-1:0]            o_out_src_val,
  output logic [31:0]                       o_interlock_cnt
);

  localparam int unsigned ADDR_BUS_W = SRC_N * REG_ADDR_W;
  localparam int unsigned VAL_BUS_W  = SRC_N * REG_W;

  typedef enum logic [1:0] {ST_EMPTY, ST_ONE, ST_FULL} buf_state_t;

  buf_state_t              r_state;
  logic                    r_out_valid;
  logic [PAYLOAD_W-1:0]    r_out_payload;
  logic [ADDR_BUS_W-1:0]   r_out_addr;
  logic [VAL_BUS_W-1:0]    r_out_val;
  logic [PAYLOAD_W-1:0]    r_skid_payload;
  logic [ADDR_BUS_W-1:0]   r_skid_addr;
  logic [VAL_BUS_W-1:0]    r_skid_val;
  logic [31:0]             r_cnt;

  logic [VAL_BUS_W-1:0]    w_sel_val;
  logic                    w_hazard;
  logic                    w_skid_valid;
  logic                    w_accept;

  // Operand selection and load-use detection per channel.
  // Layers are scanned from the oldest up so younger producers overwrite older ones.
  always_comb begin : operand_sel
    logic [REG_ADDR_W-1:0] v_a;
    logic [REG_W-1:0]      v_val;
    w_sel_val = '0;
    w_hazard  = 1'b0;
    v_a       = '0;
    v_val     = '0;
    for (int unsigned i = 0; i < SRC_N; i++) begin
      v_a   = i_in_src_addr[i*REG_ADDR_W +: REG_ADDR_W];
      v_val = i_gpr[int'(v_a)*REG_W +: REG_W];
      for (int k = int'(EW_LAYER); k >= 0; k--) begin
        if (i_wri_wen[k] && (i_wri_addr[k*REG_ADDR_W +: REG_ADDR_W] == v_a)) begin
          v_val = i_wri_val[k*REG_W +: REG_W];
        end
      end
      if (i_exe_wen && !i_exe_is_load && (i_exe_addr == v_a)) begin
        v_val = i_exe_val;
      end
      if (!i_in_src_use[i]) begin
        v_val = '0;
      end
      w_sel_val[i*REG_W +: REG_W] = v_val;
      if (i_in_src_use[i] && i_exe_wen && i_exe_is_load && (i_exe_addr == v_a)) begin
        w_hazard = 1'b1;
      end
    end
  end

  assign w_skid_valid = (r_state == ST_FULL);
  assign o_in_ready   = ~w_skid_valid & ~w_hazard & ~i_flush & ~i_rst;
  assign w_accept     = i_in_valid & o_in_ready;

  // Output/skid buffer control and interlock counter.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state        <= ST_EMPTY;
      r_out_valid    <= 1'b0;
      r_out_payload  <= '0;
      r_out_addr     <= '0;
      r_out_val      <= '0;
      r_skid_payload <= '0;
      r_skid_addr    <= '0;
      r_skid_val     <= '0;
      r_cnt          <= '0;
    end else begin
      if (i_in_valid && w_hazard && !w_skid_valid && !i_flush && (r_cnt != 32'hFFFF_FFFF)) begin
        r_cnt <= r_cnt + 32'd1;
      end
      if (i_flush) begin
        r_state     <= ST_EMPTY;
        r_out_valid <= 1'b0;
      end else begin
        case (r_state)
          ST_EMPTY: begin
            if (w_accept) begin
              r_state       <= ST_ONE;
              r_out_valid   <= 1'b1;
              r_out_payload <= i_in_payload;
              r_out_addr    <= i_in_src_addr;
              r_out_val     <= w_sel_val;
            end
          end
          ST_ONE: begin
            if (w_accept && i_out_ready) begin
              r_out_payload <= i_in_payload;
              r_out_addr    <= i_in_src_addr;
              r_out_val     <= w_sel_val;
            end else if (w_accept) begin
              // Output is stalled: park the new entry in the skid slot.
              r_state        <= ST_FULL;
              r_skid_payload <= i_in_payload;
              r_skid_addr    <= i_in_src_addr;
              r_skid_val     <= w_sel_val;
            end else if (i_out_ready) begin
              r_state     <= ST_EMPTY;
              r_out_valid <= 1'b0;
            end
          end
          ST_FULL: begin
            if (i_out_ready) begin
              r_state       <= ST_ONE;
              r_out_payload <= r_skid_payload;
              r_out_addr    <= r_skid_addr;
              r_out_val     <= r_skid_val;
            end
          end
          default: begin
            r_state     <= ST_EMPTY;
            r_out_valid <= 1'b0;
          end
        endcase
      end
    end
  end

  assign o_out_valid     = r_out_valid;
  assign o_out_payload   = r_out_payload;
  assign o_out_src_addr  = r_out_addr;
  assign o_out_src_val   = r_out_val;
  assign o_interlock_cnt = r_cnt;

endmodule

// File: tb/tb_decode_operand_stage.sv
// Bench for decode_operand_stage: directed scenarios followed by random traffic,
// all checked against a queue-based behavioural model of the stage.
module tb_decode_operand_stage;
  localparam int SRC_N = 3;
  localparam int WL    = 2;
  localparam int REG_W = 64;
  localparam int AW    = 4;
  localparam int REG_N = 16;
  localparam int PW    = 128;

  logic                  clk = 1'b0;
  logic                  rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [PW-1:0]         in_payload, out_payload;
  logic [SRC_N*AW-1:0]   in_src_addr, out_src_addr;
  logic [SRC_N-1:0]      in_src_use;
  logic [REG_N*REG_W-1:0] gpr;
  logic                  exe_wen, exe_is_load;
  logic [AW-1:0]         exe_addr;
  logic [REG_W-1:0]      exe_val;
  logic [WL-1:0]         wri_wen;
  logic [WL*AW-1:0]      wri_addr;
  logic [WL*REG_W-1:0]   wri_val;
  logic [SRC_N*REG_W-1:0] out_src_val;
  logic [31:0]           interlock_cnt;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [PW-1:0]          p;
    logic [SRC_N*AW-1:0]    a;
    logic [SRC_N*REG_W-1:0] v;
  } ent_t;

  ent_t          mq[$];
  ent_t          ed;
  logic [31:0]   m_cnt;
  logic [PW-1:0] drained[$];

  always #5 clk = ~clk;

  decode_operand_stage dut (
    .i_clk(clk), .i_rst(rst), .i_flush(flush),
    .i_in_valid(in_valid), .o_in_ready(in_ready), .i_in_payload(in_payload),
    .i_in_src_addr(in_src_addr), .i_in_src_use(in_src_use), .i_gpr(gpr),
    .i_exe_wen(exe_wen), .i_exe_is_load(exe_is_load), .i_exe_addr(exe_addr), .i_exe_val(exe_val),
    .i_wri_wen(wri_wen), .i_wri_addr(wri_addr), .i_wri_val(wri_val),
    .o_out_valid(out_valid), .i_out_ready(out_ready), .o_out_payload(out_payload),
    .o_out_src_addr(out_src_addr), .o_out_src_val(out_src_val), .o_interlock_cnt(interlock_cnt)
  );

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference operand: youngest producer wins, loads in execute never forward.
  function automatic logic [REG_W-1:0] ref_val(int i);
    logic [AW-1:0] a;
    a = in_src_addr[i*AW +: AW];
    if (!in_src_use[i]) return '0;
    if (exe_wen && !exe_is_load && exe_addr == a) return exe_val;
    for (int k = 0; k < WL; k++)
      if (wri_wen[k] && wri_addr[k*AW +: AW] == a) return wri_val[k*REG_W +: REG_W];
    return gpr[int'(a)*REG_W +: REG_W];
  endfunction

  function automatic bit ref_hazard();
    bit h = 1'b0;
    for (int i = 0; i < SRC_N; i++)
      if (in_src_use[i] && exe_wen && exe_is_load && exe_addr == in_src_addr[i*AW +: AW]) h = 1'b1;
    return h;
  endfunction

  // One clock: check in_ready, advance the model at the edge, check outputs after it.
  task automatic cycle();
    ent_t e;
    bit hz, rdy, acc;
    #1;
    hz  = ref_hazard();
    rdy = (mq.size() < 2) && !hz && !flush && !rst;
    chk("in_ready", in_ready, rdy);
    acc = in_valid && rdy;
    e.p = in_payload;
    e.a = in_src_addr;
    for (int i = 0; i < SRC_N; i++) e.v[i*REG_W +: REG_W] = ref_val(i);
    @(posedge clk);
    if (rst) begin
      mq.delete();
      m_cnt = '0;
      ed.p = '0; ed.a = '0; ed.v = '0;
    end else begin
      if (in_valid && hz && mq.size() < 2 && !flush && m_cnt != 32'hFFFF_FFFF) m_cnt++;
      if (flush) mq.delete();
      else begin
        if (out_ready && mq.size() > 0) drained.push_back(mq.pop_front().p);
        if (acc) mq.push_back(e);
      end
      if (mq.size() > 0) ed = mq[0];
    end
    #1;
    chk("out_valid", out_valid, mq.size() > 0);
    if (mq.size() > 0 || rst) begin
      chk("out_payload", out_payload, ed.p);
      chk("out_src_addr", out_src_addr, ed.a);
      chk("out_src_val", out_src_val, ed.v);
    end
    chk("interlock_cnt", interlock_cnt, m_cnt);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_payload = '0; in_src_addr = '0; in_src_use = '0;
    exe_wen = 1'b0; exe_is_load = 1'b0; exe_addr = '0; exe_val = '0;
    wri_wen = '0; wri_addr = '0; wri_val = '0;
    for (int r = 0; r < REG_N; r++) gpr[r*REG_W +: REG_W] = {$urandom, $urandom};
    gpr[3*REG_W +: REG_W] = 64'h11;
    m_cnt = '0;
    ed.p = '0; ed.a = '0; ed.v = '0;
    @(posedge clk); #1;

    // Reset state
    cycle();
    cycle();
    rst = 1'b0;

    // Forwarding priority on r3
    in_valid = 1'b1; out_ready = 1'b1; in_payload = 128'hA1;
    in_src_use = 3'b001; in_src_addr = {4'd0, 4'd0, 4'd3};
    wri_wen = 2'b11; wri_addr = {4'd3, 4'd3}; wri_val = {64'h22, 64'h33};
    exe_wen = 1'b1; exe_is_load = 1'b0; exe_addr = 4'd3; exe_val = 64'h44;
    cycle(); chk("fwd_exe", out_src_val[63:0], 64'h44);
    chk("fwd_unused_ch", out_src_val[191:64], 128'h0);
    exe_wen = 1'b0;
    cycle(); chk("fwd_wri0", out_src_val[63:0], 64'h33);
    wri_wen = 2'b10;
    cycle(); chk("fwd_wri1", out_src_val[63:0], 64'h22);
    wri_wen = 2'b00;
    cycle(); chk("fwd_gpr", out_src_val[63:0], 64'h11);

    // Load-use interlock on r5
    in_payload = 128'hB1; in_src_use = 3'b010; in_src_addr = {4'd0, 4'd5, 4'd0};
    exe_wen = 1'b1; exe_is_load = 1'b1; exe_addr = 4'd5;
    #1 chk("lu_in_ready", in_ready, 1'b0);
    cycle(); chk("lu_cnt", interlock_cnt, 32'd1);
    exe_wen = 1'b0; wri_wen = 2'b01; wri_addr = {4'd0, 4'd5}; wri_val = {64'h0, 64'hAB};
    cycle(); chk("lu_fwd", out_src_val[127:64], 64'hAB);
    chk("lu_payload", out_payload, 128'hB1);
    wri_wen = 2'b00; exe_wen = 1'b1; exe_is_load = 1'b1; in_src_use = 3'b000; in_payload = 128'hB2;
    cycle(); chk("lu_unused_cnt", interlock_cnt, 32'd1);
    chk("lu_unused_val", out_src_val[127:64], 64'h0);
    exe_wen = 1'b0;

    // Backpressure: 1,2,3 through output + skid
    in_valid = 1'b0; cycle();
    drained.delete();
    in_valid = 1'b1; in_payload = 128'd1; out_ready = 1'b1; cycle();
    in_payload = 128'd2; out_ready = 1'b0; cycle();
    in_payload = 128'd3; cycle();
    chk("bp_hold_out", out_payload, 128'd1);
    #1 chk("bp_full_ready", in_ready, 1'b0);
    out_ready = 1'b1; cycle();
    cycle();
    in_valid = 1'b0; cycle();
    chk("bp_count", drained.size(), 3);
    if (drained.size() == 3) begin
      chk("bp_order0", drained[0], 128'd1);
      chk("bp_order1", drained[1], 128'd2);
      chk("bp_order2", drained[2], 128'd3);
    end

    // Flush with full buffer and pending input
    in_valid = 1'b1; out_ready = 1'b0; in_payload = 128'd4; cycle();
    in_payload = 128'd5; cycle();
    flush = 1'b1; in_payload = 128'd6; out_ready = 1'b1; cycle();
    chk("flush_valid", out_valid, 1'b0);
    out_ready = 1'b0; cycle();
    flush = 1'b0; in_valid = 1'b0; cycle();
    chk("flush_after", out_valid, 1'b0);

    // Reset during an interlock stall with count 7
    in_valid = 1'b1; in_payload = 128'hC1; in_src_use = 3'b010; in_src_addr = {4'd0, 4'd5, 4'd0};
    exe_wen = 1'b1; exe_is_load = 1'b1; exe_addr = 4'd5;
    repeat (6) cycle();
    chk("stall_cnt7", interlock_cnt, 32'd7);
    rst = 1'b1; cycle();
    chk("rst_cnt", interlock_cnt, 32'd0);
    chk("rst_payload", out_payload, 128'h0);
    chk("rst_val", out_src_val, 192'h0);
    rst = 1'b0;

    // Saturation from a near-max start
    force dut.r_cnt = 32'hFFFF_FFFD;
    #1 release dut.r_cnt;
    m_cnt = 32'hFFFF_FFFD;
    repeat (4) cycle();
    chk("sat_cnt", interlock_cnt, 32'hFFFF_FFFF);
    exe_wen = 1'b0; in_valid = 1'b0; cycle();

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      rst         = ($urandom % 64) == 0;
      flush       = ($urandom % 16) == 0;
      in_valid    = $urandom % 2;
      out_ready   = ($urandom % 4) != 0;
      in_payload  = {$urandom, $urandom, $urandom, $urandom};
      in_src_use  = 3'($urandom);
      for (int i = 0; i < SRC_N; i++) in_src_addr[i*AW +: AW] = 4'($urandom_range(0, 3));
      exe_wen     = $urandom % 2;
      exe_is_load = ($urandom % 3) == 0;
      exe_addr    = 4'($urandom_range(0, 3));
      exe_val     = {$urandom, $urandom};
      wri_wen     = 2'($urandom);
      for (int k = 0; k < WL; k++) begin
        wri_addr[k*AW +: AW]      = 4'($urandom_range(0, 3));
        wri_val[k*REG_W +: REG_W] = {$urandom, $urandom};
      end
      if ($urandom % 8 == 0)
        for (int r = 0; r < REG_N; r++) gpr[r*REG_W +: REG_W] = {$urandom, $urandom};
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
